multicycle_controller: RTL

Main control FSM for the multicycle RISC-V core: sequences fetch, decode, execute, memory and writeback over several clock cycles around a single shared ALU and a single shared instruction/data memory port. It drives the datapath multiplexer selects, register/memory/PC write enables and the 2-bit `ALUop` consumed by the existing ALU decoder. It sits beside the ALU decoder in the control unit, between the instruction register opcode field and the datapath.

---
 rtl/multicycle_controller.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Main control FSM of the multicycle RISC-V core. Sequences fetch, decode,
//   execute, memory and writeback around one shared ALU and one shared
//   instruction/data memory port.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   op[6:0]    in   opcode from the instruction register
//   Zero       in   ALU zero flag
//   mem_ready  in   memory completes the current access this cycle
//   mem_req    out  memory access active (FETCH, MEMREAD, MEMWRITE)
//   PCWrite    out  PC register enable
//   AdrSrc     out  memory address select: 0 = PC, 1 = ALU result
//   MemWrite   out  memory write enable
//   IRWrite    out  instruction register / OldPC enable
//   ResultSrc  out  result mux: 00 ALUOut, 01 read data, 10 ALU result
//   ALUSrcA    out  00 PC, 01 OldPC, 10 rs1
//   ALUSrcB    out  00 rs2, 01 immediate, 10 constant 4
//   ALUop      out  00 add, 01 subtract, 10 funct-decoded
//   RegWrite   out  register file write enable
//   illegal_op out  pulse in DECODE for an unsupported opcode
//   retire     out  pulse in the final cycle of each completed instruction
//   state[3:0] out  current state, for debug
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUop,
  output logic       RegWrite,
  output logic       illegal_op,
  output logic       retire,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    ALUWB    = 4'd7,
    EXECI    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  state_t cur, nxt;

  assign state = cur;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= FETCH;
    else       cur <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:    nxt = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_R:         nxt = EXECR;
          OP_I:         nxt = EXECI;
          OP_JAL:       nxt = JAL;
          OP_BEQ:       nxt = BEQ;
          default:      nxt = FETCH;
        endcase
      end
      MEMADR:   nxt = (op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  nxt = mem_ready ? MEMWB : MEMREAD;
      MEMWB:    nxt = FETCH;
      MEMWRITE: nxt = mem_ready ? FETCH : MEMWRITE;
      EXECR:    nxt = ALUWB;
      EXECI:    nxt = ALUWB;
      JAL:      nxt = ALUWB;
      ALUWB:    nxt = FETCH;
      BEQ:      nxt = FETCH;
      default:  nxt = FETCH;
    endcase
  end

  // Output logic
  always_comb begin
    mem_req    = 1'b0;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUop      = 2'b00;
    RegWrite   = 1'b0;
    illegal_op = 1'b0;
    retire     = 1'b0;
    case (cur)
      FETCH: begin
        mem_req   = 1'b1;
        ResultSrc = 2'b10;
        ALUSrcB   = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ: illegal_op = 1'b0;
          default:                                  illegal_op = 1'b1;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: begin
        AdrSrc  = 1'b1;
        mem_req = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        retire    = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        mem_req  = 1'b1;
        retire   = mem_ready;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        ALUop   = 2'b10;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUop   = 2'b10;
      end
      JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      BEQ: begin
        ALUSrcA = 2'b10;
        ALUop   = 2'b01;
        PCWrite = Zero;
        retire  = 1'b1;
      end
      default: ;
    endcase
    // Reset also masks the enables directly, so nothing is written between
    // reset rising and the state register settling to FETCH.
    if (reset) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      retire     = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule
